hub75_bcm_driver: RTL and testbench

Parametrised HUB75 scan engine for the retro_paint display path, replacing the fixed 64x64 scan logic inside the GPU. It walks a framebuffer through a 1-cycle-latency read port, shifts one bit-plane per row into the panel, and weights each plane with binary-code-modulated (BCM) output-enable time. Compared with the current fixed driver, it adds runtime global brightness, a frame-start strobe for buffer swapping, and a clean enable/idle mode. It sits between the GPU frame/overlay memory and the wire_to_screen_* pins.

---
 rtl/hub75_bcm_driver.sv | 185 ++++++++++++++++++
 tb/tb_hub75_bcm_driver.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_driver.sv
// HUB75 scan engine: reads a framebuffer through a 1-cycle-latency port, shifts one
// bit-plane per row into the panel and weights each plane with BCM output-enable time.
module hub75_bcm_driver #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int BPC      = 8,
  parameter int CLK_DIV  = 2,
  parameter int BASE_OE  = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              enable,
  input  logic [7:0]                        brightness,
  output logic                              fb_rd_en,
  output logic [ROW_BITS+$clog2(COLS)-1:0]  fb_addr,
  input  logic [3*BPC-1:0]                  fb_data_top,
  input  logic [3*BPC-1:0]                  fb_data_bot,
  output logic [2:0]                        to_screen_RGB0,
  output logic [2:0]                        to_screen_RGB1,
  output logic                              to_screen_CLK,
  output logic                              to_screen_LATCH,
  output logic                              to_screen_nOE,
  output logic [ROW_BITS-1:0]               to_screen_ABCDE,
  output logic                              frame_start
);

  localparam int COL_BITS = $clog2(COLS);
  localparam int PB       = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int P_MAX    = BASE_OE << (BPC - 1);
  localparam int DW       = $clog2(P_MAX + 1);
  localparam int SW       = $clog2(2 * CLK_DIV);
  localparam int CW       = (DW > SW) ? DW : SW;
  localparam int PW       = DW + 8;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY
  } state_t;

  state_t              state;
  logic [CW-1:0]       cyc;
  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic [PB-1:0]       plane;
  logic [7:0]          bright_q;
  logic [DW-1:0]       on_q;
  logic [DW-1:0]       period;
  logic [DW-1:0]       on_c;
  logic [BPC-1:0]      r_top, g_top, b_top, r_bot, g_bot, b_bot;
  logic [2:0]          pix_top, pix_bot;

  always_comb begin
    period  = DW'(BASE_OE) << plane;
    // (period * (bright+1)) >> 8 never exceeds period, so DW bits always suffice
    on_c    = DW'((PW'(period) * (PW'(bright_q) + PW'(1))) >> 8);
    r_top   = fb_data_top[3*BPC-1 -: BPC];
    g_top   = fb_data_top[2*BPC-1 -: BPC];
    b_top   = fb_data_top[BPC-1:0];
    r_bot   = fb_data_bot[3*BPC-1 -: BPC];
    g_bot   = fb_data_bot[2*BPC-1 -: BPC];
    b_bot   = fb_data_bot[BPC-1:0];
    pix_top = {r_top[plane], g_top[plane], b_top[plane]};
    pix_bot = {r_bot[plane], g_bot[plane], b_bot[plane]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= S_IDLE;
      cyc             <= '0;
      col             <= '0;
      row             <= '0;
      plane           <= '0;
      bright_q        <= '0;
      on_q            <= '0;
      fb_rd_en        <= 1'b0;
      fb_addr         <= '0;
      to_screen_RGB0  <= '0;
      to_screen_RGB1  <= '0;
      to_screen_CLK   <= 1'b0;
      to_screen_LATCH <= 1'b0;
      to_screen_nOE   <= 1'b1;
      to_screen_ABCDE <= '0;
      frame_start     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state       <= S_START;
            frame_start <= 1'b1;
          end
        end

        S_START: begin
          frame_start <= 1'b0;
          bright_q    <= brightness;
          row         <= '0;
          plane       <= '0;
          col         <= '0;
          cyc         <= '0;
          fb_rd_en    <= 1'b1;
          fb_addr     <= '0;
          state       <= S_SHIFT;
        end

        S_SHIFT: begin
          fb_rd_en <= 1'b0;
          if (cyc == CW'(1)) begin
            to_screen_RGB0 <= pix_top;
            to_screen_RGB1 <= pix_bot;
          end
          if (cyc == CW'(2 * CLK_DIV - 1)) begin
            cyc           <= '0;
            to_screen_CLK <= 1'b0;
            if (col == COL_BITS'(COLS - 1)) begin
              state <= S_BLANK;
            end else begin
              col      <= col + 1'b1;
              fb_rd_en <= 1'b1;
              fb_addr  <= {row, col + 1'b1};
            end
          end else begin
            cyc           <= cyc + 1'b1;
            to_screen_CLK <= (cyc >= CW'(CLK_DIV - 1));
          end
        end

        S_BLANK: begin
          state           <= S_LATCH;
          cyc             <= '0;
          to_screen_LATCH <= 1'b1;
          to_screen_ABCDE <= row;
        end

        S_LATCH: begin
          if (cyc == CW'(1)) begin
            to_screen_LATCH <= 1'b0;
            state           <= S_DISPLAY;
            cyc             <= '0;
            on_q            <= on_c;
            to_screen_nOE   <= (on_c == '0);
          end else begin
            cyc <= cyc + 1'b1;
          end
        end

        S_DISPLAY: begin
          if (cyc == CW'(period) - CW'(1)) begin
            to_screen_nOE <= 1'b1;
            cyc           <= '0;
            col           <= '0;
            if (plane != PB'(BPC - 1)) begin
              plane    <= plane + 1'b1;
              state    <= S_SHIFT;
              fb_rd_en <= 1'b1;
              fb_addr  <= {row, {COL_BITS{1'b0}}};
            end else if (row != '1) begin
              plane    <= '0;
              row      <= row + 1'b1;
              state    <= S_SHIFT;
              fb_rd_en <= 1'b1;
              fb_addr  <= {row + 1'b1, {COL_BITS{1'b0}}};
            end else begin
              plane <= '0;
              if (enable) begin
                state       <= S_START;
                frame_start <= 1'b1;
              end else begin
                state           <= S_IDLE;
                fb_addr         <= '0;
                to_screen_RGB0  <= '0;
                to_screen_RGB1  <= '0;
                to_screen_ABCDE <= '0;
              end
            end
          end else begin
            cyc           <= cyc + 1'b1;
            to_screen_nOE <= !((cyc + CW'(1)) < CW'(on_q));
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Bench for hub75_bcm_driver: frame-position model checked every cycle, plus
// directed literal checks on shift order, BCM widths, frame spacing and stop/abort.
module tb_hub75_bcm_driver;
  localparam int COLS     = 4;
  localparam int ROW_BITS = 1;
  localparam int BPC      = 2;
  localparam int CLK_DIV  = 2;
  localparam int BASE_OE  = 4;
  localparam int AW       = ROW_BITS + $clog2(COLS);
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int SH       = COLS * 2 * CLK_DIV;
  localparam int ROW_LEN  = BPC * (SH + 3) + BASE_OE * ((1 << BPC) - 1);
  localparam int FRAME    = 1 + ROWS * ROW_LEN;

  logic              clk = 1'b0;
  logic              rstn;
  logic              enable;
  logic [7:0]        brightness;
  logic              fb_rd_en;
  logic [AW-1:0]     fb_addr;
  logic [3*BPC-1:0]  fb_data_top = '0;
  logic [3*BPC-1:0]  fb_data_bot = '0;
  logic [2:0]        to_screen_RGB0, to_screen_RGB1;
  logic              to_screen_CLK, to_screen_LATCH, to_screen_nOE;
  logic [ROW_BITS-1:0] to_screen_ABCDE;
  logic              frame_start;

  hub75_bcm_driver #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .BPC(BPC), .CLK_DIV(CLK_DIV), .BASE_OE(BASE_OE)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .brightness(brightness),
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr),
    .fb_data_top(fb_data_top), .fb_data_bot(fb_data_bot),
    .to_screen_RGB0(to_screen_RGB0), .to_screen_RGB1(to_screen_RGB1),
    .to_screen_CLK(to_screen_CLK), .to_screen_LATCH(to_screen_LATCH),
    .to_screen_nOE(to_screen_nOE), .to_screen_ABCDE(to_screen_ABCDE),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // {R,G,B} 2 bits each
  logic [5:0] mem_top [8] = '{6'b011011, 6'b110100, 6'b101001, 6'b000111,
                              6'b111000, 6'b010101, 6'b100110, 6'b001110};
  logic [5:0] mem_bot [8] = '{6'b100100, 6'b001011, 6'b010110, 6'b111000,
                              6'b000111, 6'b101010, 6'b011001, 6'b110001};

  always @(posedge clk) begin
    if (fb_rd_en) begin
      fb_data_top <= mem_top[fb_addr];
      fb_data_bot <= mem_bot[fb_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pix(input logic [5:0] d, input int p);
    logic [5:0] s;
    s = d >> p;
    return {s[2*BPC], s[BPC], s[0]};
  endfunction

  function automatic int plane_len(input int b);
    return SH + 3 + (BASE_OE << b);
  endfunction

  typedef struct packed {
    logic fs, noe, clk, lat, rd, chk_addr, chk_rgb, chk_row;
    logic [AW-1:0] addr;
    logic [2:0] rgb0, rgb1;
    logic [ROW_BITS-1:0] row;
  } exp_t;

  // Expected pins from position in frame (-1 = idle) and latched brightness
  function automatic exp_t model(input int p, input logic [7:0] b);
    exp_t e;
    int u, w, r, pl, per, on, slot, k, a;
    e = '0;
    e.noe = 1'b1;
    if (p < 0) begin
      e.chk_addr = 1'b1; e.chk_rgb = 1'b1; e.chk_row = 1'b1;
      return e;
    end
    if (p == 0) begin
      e.fs = 1'b1;
      return e;
    end
    u = p - 1;
    r = u / ROW_LEN;
    w = u % ROW_LEN;
    pl = 0;
    while (pl < BPC - 1 && w >= plane_len(pl)) begin
      w -= plane_len(pl);
      pl++;
    end
    per = BASE_OE << pl;
    on = (per * (int'(b) + 1)) >> 8;
    e.row = ROW_BITS'(r);
    e.chk_row = (pl > 0) || (w > SH);
    e.chk_addr = 1'b1;
    e.chk_rgb = 1'b1;
    if (w < SH) begin
      slot = w / (2 * CLK_DIV);
      k = w % (2 * CLK_DIV);
      e.clk = (k >= CLK_DIV);
      e.rd = (k == 0);
      e.addr = AW'(r * COLS + slot);
      if (k >= 2) a = r * COLS + slot;
      else if (slot > 0) a = r * COLS + slot - 1;
      else begin a = 0; e.chk_rgb = 1'b0; end
    end else begin
      a = r * COLS + COLS - 1;
      e.addr = AW'(a);
      if (w > SH && w < SH + 3) e.lat = 1'b1;
      else if (w >= SH + 3) e.noe = !((w - SH - 3) < on);
    end
    e.rgb0 = pix(mem_top[a], pl);
    e.rgb1 = pix(mem_bot[a], pl);
    return e;
  endfunction

  int         pos = -1;
  logic [7:0] b_m = '0;
  bit         chk_on = 1'b0;

  always @(posedge clk) begin
    if (!rstn) pos <= -1;
    else if (pos < 0) pos <= enable ? 0 : -1;
    else if (pos == FRAME - 1) pos <= enable ? 0 : -1;
    else pos <= pos + 1;
    if (rstn && pos == 0) b_m <= brightness;
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_on) begin
      e = model(pos, b_m);
      check("frame_start", frame_start, e.fs);
      check("nOE", to_screen_nOE, e.noe);
      check("CLK", to_screen_CLK, e.clk);
      check("LATCH", to_screen_LATCH, e.lat);
      check("fb_rd_en", fb_rd_en, e.rd);
      if (e.chk_addr) check("fb_addr", fb_addr, e.addr);
      if (e.chk_rgb) begin
        check("RGB0", to_screen_RGB0, e.rgb0);
        check("RGB1", to_screen_RGB1, e.rgb1);
      end
      if (e.chk_row) check("ABCDE", to_screen_ABCDE, e.row);
    end
  end

  int addr_q[$], rgb0_q[$], rgb1_q[$], rise_q[$], noe_q[$], lat_q[$];

  task automatic observe(input int n_max, input bit stop_fs, input int chg_at,
                         input bit chg_en, input logic [7:0] chg_val, output int len);
    int rises, noe_run, lat_run;
    logic prev_clk, prev_lat;
    addr_q.delete(); rgb0_q.delete(); rgb1_q.delete();
    rise_q.delete(); noe_q.delete(); lat_q.delete();
    rises = 0; noe_run = 0; lat_run = 0;
    prev_clk = to_screen_CLK; prev_lat = to_screen_LATCH;
    len = -1;
    for (int i = 1; i <= n_max; i++) begin
      @(negedge clk);
      if (i == chg_at) begin
        if (chg_en) enable = chg_val[0];
        else brightness = chg_val;
      end
      if (fb_rd_en) addr_q.push_back(int'(fb_addr));
      if (to_screen_CLK && !prev_clk) begin
        rises++;
        rgb0_q.push_back(int'(to_screen_RGB0));
        rgb1_q.push_back(int'(to_screen_RGB1));
      end
      if (to_screen_LATCH && !prev_lat) begin
        rise_q.push_back(rises);
        rises = 0;
      end
      if (!to_screen_nOE) noe_run++;
      else if (noe_run > 0) begin noe_q.push_back(noe_run); noe_run = 0; end
      if (to_screen_LATCH) lat_run++;
      else if (lat_run > 0) begin lat_q.push_back(lat_run); lat_run = 0; end
      prev_clk = to_screen_CLK;
      prev_lat = to_screen_LATCH;
      if (stop_fs && frame_start) begin
        len = i;
        break;
      end
    end
  endtask

  task automatic check_runs(input string name, input int q[$], input int a, input int b);
    check({name, " count"}, q.size(), 4);
    if (q.size() == 4) begin
      check({name, " r0p0"}, q[0], a);
      check({name, " r0p1"}, q[1], b);
      check({name, " r1p0"}, q[2], a);
      check({name, " r1p1"}, q[3], b);
    end
  endtask

  task automatic wait_fs(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (frame_start) seen = 1'b1;
    end
    check("frame_start seen", seen, 1'b1);
  endtask

  int exp_addr[16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};

  initial begin
    int len;
    bit seen;
    rstn = 1'b0; enable = 1'b0; brightness = 8'd255;
    repeat (5) @(negedge clk);
    chk_on = 1'b1;
    check("rst nOE", to_screen_nOE, 1'b1);
    check("rst CLK", to_screen_CLK, 1'b0);
    check("rst LATCH", to_screen_LATCH, 1'b0);
    check("rst ABCDE", to_screen_ABCDE, 0);
    check("rst RGB0", to_screen_RGB0, 0);
    check("rst RGB1", to_screen_RGB1, 0);
    check("rst rd_en", fb_rd_en, 1'b0);

    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("idle nOE", to_screen_nOE, 1'b1);
    check("idle frame_start", frame_start, 1'b0);

    // frame 1 at full brightness; brightness drops to 127 mid-frame
    enable = 1'b1;
    wait_fs(5);
    observe(300, 1'b1, 10, 1'b0, 8'd127, len);
    check("frame spacing f1", len, 101);
    check("addr count", addr_q.size(), 16);
    if (addr_q.size() == 16)
      for (int i = 0; i < 16; i++) check("addr order", addr_q[i], exp_addr[i]);
    check("RGB0 pix0 plane0", rgb0_q[0], 3'b101);
    check("RGB0 pix0 plane1", rgb0_q[4], 3'b011);
    check("RGB1 pix0 plane0", rgb1_q[0], 3'b010);
    check_runs("CLK rises", rise_q, 4, 4);
    check_runs("nOE low 255", noe_q, 4, 8);
    check_runs("LATCH width", lat_q, 2, 2);

    // frame 2 uses 127; brightness drops to 0 mid-frame
    observe(300, 1'b1, 10, 1'b0, 8'd0, len);
    check("frame spacing f2", len, 101);
    check_runs("nOE low 127", noe_q, 2, 4);

    // frame 3 at 0; enable drops in row 0, frame still completes then idles
    observe(130, 1'b0, 10, 1'b1, 8'd0, len);
    check("nOE low 0 runs", noe_q.size(), 0);
    check_runs("LATCH f3", lat_q, 2, 2);
    check("f3 reads", addr_q.size(), 16);
    check("stop nOE", to_screen_nOE, 1'b1);
    check("stop CLK", to_screen_CLK, 1'b0);
    check("stop frame_start", frame_start, 1'b0);

    // reset during DISPLAY
    brightness = 8'd255;
    enable = 1'b1;
    wait_fs(5);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (!to_screen_nOE) seen = 1'b1;
    end
    check("display reached", seen, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    check("abort nOE", to_screen_nOE, 1'b1);
    check("abort LATCH", to_screen_LATCH, 1'b0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
